// File: rtl/avr_instruction_encoder_pkg.sv
// Shared definitions for the AVR encoder: opcode IDs (common with the
// instruction selector), fixed single-word encodings and FSM state encoding.
package avr_instruction_encoder_pkg;

  localparam logic [7:0] ERROR = 8'd0;
  localparam logic [7:0] LDI   = 8'd1;
  localparam logic [7:0] JMP   = 8'd2;
  localparam logic [7:0] CALL  = 8'd3;
  localparam logic [7:0] OUT   = 8'd4;
  localparam logic [7:0] RET   = 8'd5;
  localparam logic [7:0] CLI   = 8'd6;
  localparam logic [7:0] RJMP  = 8'd7;
  localparam logic [7:0] EOR   = 8'd8;

  localparam logic [15:0] RET_WORD = 16'h9508;
  localparam logic [15:0] CLI_WORD = 16'h94F8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EMIT1 = 2'd1,
    ST_EMIT2 = 2'd2
  } enc_state_t;

endpackage

// File: rtl/avr_instruction_encoder_word_builder.sv
// Combinational AVR word builder: opcode ID plus operands -> one or two
// machine words, with a flag for requests that have no legal encoding.
module avr_word_builder
  import avr_instruction_encoder_pkg::*;
#(
  parameter int OPC_W = 8
) (
  input  logic [OPC_W-1:0] i_opcode,
  input  logic [4:0]       i_rd,
  input  logic [4:0]       i_rr,
  input  logic [21:0]      i_imm,
  output logic [15:0]      o_word1,
  output logic [15:0]      o_word2,
  output logic             o_two_word,
  output logic             o_illegal
);

  // Encode per opcode; anything not listed (including ERROR) is illegal.
  always_comb begin
    o_word1    = '0;
    o_word2    = '0;
    o_two_word = 1'b0;
    o_illegal  = 1'b0;
    case (i_opcode)
      OPC_W'(LDI): begin
        // d is 16..31, so (d-16)[3:0] is simply d[3:0]; d[4]=0 is illegal.
        o_word1   = {4'b1110, i_imm[7:4], i_rd[3:0], i_imm[3:0]};
        o_illegal = ~i_rd[4];
      end
      OPC_W'(JMP): begin
        o_word1    = {7'b1001010, i_imm[21:17], 3'b110, i_imm[16]};
        o_word2    = i_imm[15:0];
        o_two_word = 1'b1;
      end
      OPC_W'(CALL): begin
        o_word1    = {7'b1001010, i_imm[21:17], 3'b111, i_imm[16]};
        o_word2    = i_imm[15:0];
        o_two_word = 1'b1;
      end
      OPC_W'(OUT):  o_word1 = {5'b10111, i_imm[5:4], i_rr, i_imm[3:0]};
      OPC_W'(RET):  o_word1 = RET_WORD;
      OPC_W'(CLI):  o_word1 = CLI_WORD;
      OPC_W'(RJMP): o_word1 = {4'b1100, i_imm[11:0]};
      OPC_W'(EOR):  o_word1 = {6'b001001, i_rr[4], i_rd, i_rr[3:0]};
      default:      o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/avr_instruction_encoder.sv
// AVR instruction encoder: accepts one request at a time in IDLE, then
// streams its one or two words with an auto-incrementing word address.
module avr_instruction_encoder
  import avr_instruction_encoder_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int OPC_W  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OPC_W-1:0]  in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rr,
  input  logic [21:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_word,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              err,
  output logic              err_sticky
);

  enc_state_t        r_state;
  enc_state_t        w_next_state;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_word1;
  logic [15:0]       r_word2;
  logic              r_two_word;
  logic              r_err;
  logic              r_err_sticky;

  logic [15:0]       w_word1;
  logic [15:0]       w_word2;
  logic              w_two_word;
  logic              w_illegal;
  logic              w_take;
  logic              w_fire;

  avr_word_builder #(
    .OPC_W (OPC_W)
  ) u_word_builder (
    .i_opcode   (in_opcode),
    .i_rd       (in_rd),
    .i_rr       (in_rr),
    .i_imm      (in_imm),
    .o_word1    (w_word1),
    .o_word2    (w_word2),
    .o_two_word (w_two_word),
    .o_illegal  (w_illegal)
  );

  assign w_take = (r_state == ST_IDLE) && in_valid;
  assign w_fire = out_valid && out_ready;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next_state;
  end

  // Next-state logic: illegal requests never leave IDLE.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (in_valid && !w_illegal) w_next_state = ST_EMIT1;
      ST_EMIT1: if (out_ready) w_next_state = r_two_word ? ST_EMIT2 : ST_IDLE;
      ST_EMIT2: if (out_ready) w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // Capture words, track the word address and the error flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr       <= '0;
      r_word1      <= '0;
      r_word2      <= '0;
      r_two_word   <= 1'b0;
      r_err        <= 1'b0;
      r_err_sticky <= 1'b0;
    end else begin
      if (w_take && !w_illegal) begin
        r_word1    <= w_word1;
        r_word2    <= w_word2;
        r_two_word <= w_two_word;
      end
      // A load in IDLE lands before word1 goes out, so word1 uses load_addr.
      if ((r_state == ST_IDLE) && load_en) r_addr <= load_addr;
      else if (w_fire)                     r_addr <= r_addr + ADDR_W'(1);
      r_err <= w_take && w_illegal;
      if (w_take && w_illegal) r_err_sticky <= 1'b1;
    end
  end

  // Output decode from state; word registers are frozen while emitting.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_word  = '0;
    out_last  = 1'b0;
    case (r_state)
      ST_IDLE:  in_ready = 1'b1;
      ST_EMIT1: begin
        out_valid = 1'b1;
        out_word  = r_word1;
        out_last  = ~r_two_word;
      end
      ST_EMIT2: begin
        out_valid = 1'b1;
        out_word  = r_word2;
        out_last  = 1'b1;
      end
      default: ;
    endcase
  end

  assign out_addr   = r_addr;
  assign err        = r_err;
  assign err_sticky = r_err_sticky;

endmodule

// File: tb/tb_avr_instruction_encoder.sv
module tb_avr_instruction_encoder;
  import avr_instruction_encoder_pkg::*;

  typedef struct {
    logic [7:0]  opc;
    logic [4:0]  rd;
    logic [4:0]  rr;
    logic [21:0] imm;
    logic [15:0] w1;
    logic [15:0] w2;
    bit          two;
  } vec_t;

  typedef struct {
    logic [15:0] word;
    logic [15:0] addr;
    bit          last;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        load_en = 1'b0;
  logic [15:0] load_addr = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_opcode = '0;
  logic [4:0]  in_rd = '0;
  logic [4:0]  in_rr = '0;
  logic [21:0] in_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_word;
  logic [15:0] out_addr;
  logic        out_last;
  logic        err;
  logic        err_sticky;

  avr_instruction_encoder #(.ADDR_W(16), .OPC_W(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_en    (load_en),
    .load_addr  (load_addr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opcode  (in_opcode),
    .in_rd      (in_rd),
    .in_rr      (in_rr),
    .in_imm     (in_imm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_word   (out_word),
    .out_addr   (out_addr),
    .out_last   (out_last),
    .err        (err),
    .err_sticky (err_sticky)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          err_seen = 0;
  exp_t        q[$];
  logic [15:0] tb_addr = '0;
  vec_t        tbl[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Output monitor: scoreboard pop on accept, stability check while stalled.
  logic        hold_v = 1'b0;
  logic [15:0] hold_w, hold_a;
  logic        hold_l;
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      hold_v = 1'b0;
    end else begin
      if (err) err_seen++;
      if (out_valid) begin
        if (hold_v) begin
          check("hold_word", out_word, hold_w);
          check("hold_addr", out_addr, hold_a);
          check("hold_last", out_last, hold_l);
        end
        if (out_ready) begin
          if (q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_word: got %h at %h, expected no word", out_word, out_addr);
          end else begin
            e = q.pop_front();
            check("word", out_word, e.word);
            check("addr", out_addr, e.addr);
            check("last", out_last, e.last);
          end
          hold_v = 1'b0;
        end else begin
          hold_v = 1'b1;
          hold_w = out_word;
          hold_a = out_addr;
          hold_l = out_last;
        end
      end else begin
        hold_v = 1'b0;
      end
    end
  end

  task automatic send(input logic [7:0] opc, input logic [4:0] rd, input logic [4:0] rr,
                      input logic [21:0] imm, input bit ld, input logic [15:0] la,
                      input bit legal, input logic [15:0] w1, input logic [15:0] w2,
                      input bit two, input bit drop2);
    int k = 0;
    while (!in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid  = 1'b1;
    in_opcode = opc;
    in_rd     = rd;
    in_rr     = rr;
    in_imm    = imm;
    if (ld) begin
      load_en   = 1'b1;
      load_addr = la;
      tb_addr   = la;
    end
    if (legal) begin
      q.push_back('{word: w1, addr: tb_addr, last: !two});
      tb_addr = tb_addr + 16'd1;
      if (two && !drop2) begin
        q.push_back('{word: w2, addr: tb_addr, last: 1'b1});
        tb_addr = tb_addr + 16'd1;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    load_en  = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while ((q.size() != 0 || !in_ready) && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (q.size() != 0 || !in_ready) check("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"},   32'(in_ready),   32'd1);
    check({tag, "_out_valid"},  32'(out_valid),  32'd0);
    check({tag, "_out_word"},   32'(out_word),   32'd0);
    check({tag, "_out_addr"},   32'(out_addr),   32'd0);
    check({tag, "_out_last"},   32'(out_last),   32'd0);
    check({tag, "_err"},        32'(err),        32'd0);
    check({tag, "_err_sticky"}, 32'(err_sticky), 32'd0);
  endtask

  initial begin
    int errs0;
    logic [15:0] addr0;

    tbl[0] = '{opc: OUT,  rd: 5'd0,  rr: 5'd5,  imm: 22'h00003F, w1: 16'hBE5F, w2: 16'h0000, two: 1'b0};
    tbl[1] = '{opc: RJMP, rd: 5'd0,  rr: 5'd0,  imm: 22'h3FFFFF, w1: 16'hCFFF, w2: 16'h0000, two: 1'b0};
    tbl[2] = '{opc: EOR,  rd: 5'd1,  rr: 5'd1,  imm: 22'h000000, w1: 16'h2411, w2: 16'h0000, two: 1'b0};
    tbl[3] = '{opc: RET,  rd: 5'd9,  rr: 5'd3,  imm: 22'h123456, w1: 16'h9508, w2: 16'h0000, two: 1'b0};
    tbl[4] = '{opc: CLI,  rd: 5'd0,  rr: 5'd0,  imm: 22'h000000, w1: 16'h94F8, w2: 16'h0000, two: 1'b0};
    tbl[5] = '{opc: LDI,  rd: 5'd31, rr: 5'd7,  imm: 22'h3FFF00, w1: 16'hE0F0, w2: 16'h0000, two: 1'b0};
    tbl[6] = '{opc: EOR,  rd: 5'd31, rr: 5'd31, imm: 22'h000000, w1: 16'h27FF, w2: 16'h0000, two: 1'b0};
    tbl[7] = '{opc: OUT,  rd: 5'd12, rr: 5'd0,  imm: 22'h3FFFC0, w1: 16'hB800, w2: 16'h0000, two: 1'b0};
    tbl[8] = '{opc: JMP,  rd: 5'd0,  rr: 5'd0,  imm: 22'h2AAAAA, w1: 16'h955C, w2: 16'hAAAA, two: 1'b1};

    repeat (3) @(posedge clk);
    #1;
    check_reset_values("rst_held");
    reset_n = 1'b1;
    @(negedge clk);
    check_reset_values("rst_init");

    // ldi r17, 0xA5 at address 0
    send(LDI, 5'd17, 5'd0, 22'h0000A5, 1'b0, 16'h0, 1'b1, 16'hEA15, 16'h0, 1'b0, 1'b0);
    drain();
    check("ldi_next_addr", 32'(out_addr), 32'd1);

    for (int i = 0; i < 9; i++) begin
      send(tbl[i].opc, tbl[i].rd, tbl[i].rr, tbl[i].imm, 1'b0, 16'h0, 1'b1,
           tbl[i].w1, tbl[i].w2, tbl[i].two, 1'b0);
      drain();
    end

    // load and request in the same IDLE cycle: jmp 0x100 at 0x0040
    send(JMP, 5'd0, 5'd0, 22'h000100, 1'b1, 16'h0040, 1'b1, 16'h940C, 16'h0100, 1'b1, 1'b0);
    drain();
    check("jmp_next_addr", 32'(out_addr), 32'h42);

    // call 0x3FFFFF with EMIT2 stalled 3 cycles; a load attempt mid-stall is ignored
    send(CALL, 5'd0, 5'd0, 22'h3FFFFF, 1'b0, 16'h0, 1'b1, 16'h95FF, 16'hFFFF, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    load_en   = 1'b1;
    load_addr = 16'h1234;
    @(negedge clk);
    check("stall_valid", 32'(out_valid), 32'd1);
    check("stall_word", 32'(out_word), 32'hFFFF);
    check("stall_last", 32'(out_last), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    load_en   = 1'b0;
    out_ready = 1'b1;
    drain();
    check("call_next_addr", 32'(out_addr), 32'h44);

    // illegal requests: ldi r3, then opcode 9
    errs0 = err_seen;
    addr0 = out_addr;
    send(LDI, 5'd3, 5'd0, 22'h0000FF, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    send(8'd9, 5'd0, 5'd0, 22'h0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("err_pulses", 32'(err_seen - errs0), 32'd2);
    check("err_sticky_set", 32'(err_sticky), 32'd1);
    check("err_addr_kept", 32'(out_addr), 32'(addr0));
    send(ERROR, 5'd0, 5'd0, 22'h0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("err_pulses_op0", 32'(err_seen - errs0), 32'd3);
    check("err_sticky_hold", 32'(err_sticky), 32'd1);

    // address wrap: jmp at 0xFFFF, second word at 0x0000
    send(JMP, 5'd0, 5'd0, 22'h000ABC, 1'b1, 16'hFFFF, 1'b1, 16'h940C, 16'h0ABC, 1'b1, 1'b0);
    drain();
    check("wrap_next_addr", 32'(out_addr), 32'd1);

    // reset while EMIT2 is stalled: second word is discarded
    send(JMP, 5'd0, 5'd0, 22'h000ABC, 1'b0, 16'h0, 1'b1, 16'h940C, 16'h0ABC, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_values("rst_abort");
    repeat (2) @(posedge clk);
    #1;
    reset_n   = 1'b1;
    out_ready = 1'b1;
    check("abort_queue_empty", 32'(q.size()), 32'd0);
    @(negedge clk);
    check_reset_values("rst_after");
    tb_addr = 16'h0;

    // recovery after reset: ldi r16, 0xFF at address 0
    send(LDI, 5'd16, 5'd0, 22'h0000FF, 1'b0, 16'h0, 1'b1, 16'hEF0F, 16'h0, 1'b0, 1'b0);
    drain();
    check("recover_next_addr", 32'(out_addr), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
